// File: rtl/deserializer_unit_cell_if.sv
// Bus for the deserializer unit cell: serial line plus realign request in,
// reassembled payload word, strobe, lock flag, frame count and a state
// debug view out.
//
// Handshake: there is no back-pressure. SERIAL_IN and SYNC are sampled on
// every rising edge. PAR_VALID is a one-cycle pulse on the cycle PAR_OUT takes
// a new word. The receiver must consume the word in that cycle or read the
// held PAR_OUT later.
interface deserializer_unit_cell_if #(
  parameter int DATA_W = 16
);
  logic              SERIAL_IN;
  logic              SYNC;
  logic [DATA_W-1:0] PAR_OUT;
  logic              PAR_VALID;
  logic              LOCKED;
  logic [7:0]        FRAME_CNT;
  logic [1:0]        state_dbg;

  // Side that drives the serial line and consumes the parallel word.
  modport master (
    output SERIAL_IN,
    output SYNC,
    input  PAR_OUT,
    input  PAR_VALID,
    input  LOCKED,
    input  FRAME_CNT,
    input  state_dbg
  );

  // The deserializer itself.
  modport slave (
    input  SERIAL_IN,
    input  SYNC,
    output PAR_OUT,
    output PAR_VALID,
    output LOCKED,
    output FRAME_CNT,
    output state_dbg
  );
endinterface

// File: rtl/deserializer_unit_cell.sv
// Deserializer unit cell. Samples an LSB-first serial stream framed as
// FRAME_LEN slots. The first DATA_W slots carry payload. Each payload is
// reassembled into a parallel word and announced with a one-cycle strobe.
// A SYNC request forces realignment so that the next sampled bit is slot 0.
// Every output is registered.
module deserializer_unit_cell #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 32,
  parameter int CNT_W     = 6,
  parameter int PIPE_DLY  = 1
) (
  input logic                     CLK,
  input logic                     RESET,
  deserializer_unit_cell_if.slave bus
);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SKIP    = 2'd2
  } state_t;

  // After reset, WAIT covers the edges that come before the upstream
  // serializer's first registered bit. With no pipeline delay, capture
  // starts on the first edge.
  localparam state_t RESET_STATE = (PIPE_DLY > 0) ? ST_WAIT : ST_CAPTURE;

  // Terminal slot values. WAIT reuses the slot counter to count its edges.
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((PIPE_DLY > 0) ? PIPE_DLY - 1 : 0);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] SLOT_ONE   = CNT_W'(1);

  // When payload fills the whole frame, the skip phase disappears.
  localparam bit NO_SKIP = (DATA_W == FRAME_LEN);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  slot_q;
  logic [CNT_W-1:0]  slot_d;
  logic              cap_we;
  logic              word_done;
  logic [DATA_W-1:0] cap_q;
  logic [DATA_W-1:0] cap_next;
  logic [DATA_W-1:0] par_out_q;
  logic              par_valid_q;
  logic              locked_q;
  logic [7:0]        frame_cnt_q;

  // State and slot counter register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= RESET_STATE;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  // Next state and slot. SYNC overrides everything, so a realign always lands
  // on slot 0 of CAPTURE. Holding SYNC high parks the cell there.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    cap_we    = 1'b0;
    word_done = 1'b0;
    if (bus.SYNC) begin
      state_d = ST_CAPTURE;
      slot_d  = '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (slot_q == WAIT_LAST) begin
            state_d = ST_CAPTURE;
            slot_d  = '0;
          end else begin
            slot_d = slot_q + SLOT_ONE;
          end
        end
        ST_CAPTURE: begin
          cap_we = 1'b1;
          if (slot_q == DATA_LAST) begin
            word_done = 1'b1;
            if (NO_SKIP) begin
              state_d = ST_CAPTURE;
              slot_d  = '0;
            end else begin
              state_d = ST_SKIP;
              slot_d  = slot_q + SLOT_ONE;
            end
          end else begin
            slot_d = slot_q + SLOT_ONE;
          end
        end
        ST_SKIP: begin
          if (slot_q == FRAME_LAST) begin
            state_d = ST_CAPTURE;
            slot_d  = '0;
          end else begin
            slot_d = slot_q + SLOT_ONE;
          end
        end
        default: begin
          state_d = ST_CAPTURE;
          slot_d  = '0;
        end
      endcase
    end
  end

  // Capture word with the current serial bit already placed at its slot.
  // This is also the word published when the last payload slot is sampled.
  always_comb begin
    cap_next = cap_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (slot_q == CNT_W'(i)) begin
        cap_next[i] = bus.SERIAL_IN;
      end
    end
  end

  // Payload datapath. A SYNC discards any partial word. PAR_OUT, the strobe,
  // the frame count and the sticky lock flag move only when a word completes.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cap_q       <= '0;
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      par_valid_q <= word_done;
      if (bus.SYNC) begin
        cap_q <= '0;
      end else if (cap_we) begin
        cap_q <= cap_next;
      end
      if (word_done) begin
        par_out_q   <= cap_next;
        locked_q    <= 1'b1;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign bus.PAR_OUT   = par_out_q;
  assign bus.PAR_VALID = par_valid_q;
  assign bus.LOCKED    = locked_q;
  assign bus.FRAME_CNT = frame_cnt_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_deserializer_unit_cell.sv
// Bench for the deserializer unit cell. It checks a default-parameter
// instance against a slot-position reference model and a payload queue. It
// also checks a PIPE_DLY=0 instance against fixed expectations.
module tb_deserializer_unit_cell;
  localparam int DW = 16;
  localparam int FL = 32;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  deserializer_unit_cell_if #(.DATA_W(DW)) bus_a ();
  deserializer_unit_cell_if #(.DATA_W(DW)) bus_b ();

  deserializer_unit_cell #(.DATA_W(DW), .FRAME_LEN(FL), .CNT_W(6), .PIPE_DLY(1)) dut_a (
    .CLK   (clk),
    .RESET (rst_a),
    .bus   (bus_a)
  );

  deserializer_unit_cell #(.DATA_W(DW), .FRAME_LEN(FL), .CNT_W(6), .PIPE_DLY(0)) dut_b (
    .CLK   (clk),
    .RESET (rst_b),
    .bus   (bus_b)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model. m_pos is the frame slot that the next edge samples.
  // Negative values are edges still to be discarded after reset.
  int            m_pos;
  int            m_cnt;
  int            e_cnt;
  logic [DW-1:0] m_bits;
  logic [DW-1:0] m_out;
  logic          m_valid;
  logic          m_locked;
  logic [DW-1:0] exp_q[$];

  task automatic model_reset();
    m_pos    = -1;
    m_cnt    = 0;
    e_cnt    = 0;
    m_bits   = '0;
    m_out    = '0;
    m_valid  = 1'b0;
    m_locked = 1'b0;
    exp_q.delete();
  endtask

  // Driver task: present one bit and a SYNC value, clock one edge, advance
  // the model, then settle 1ns past the edge so outputs can be sampled.
  task automatic drive_edge(input logic s, input logic y);
    bus_a.SERIAL_IN = s;
    bus_a.SYNC      = y;
    @(posedge clk);
    e_cnt++;
    m_valid = 1'b0;
    if (y) begin
      m_pos  = 0;
      m_bits = '0;
    end else if (m_pos < 0) begin
      m_pos++;
    end else begin
      if (m_pos < DW) begin
        m_bits[m_pos] = s;
        if (m_pos == DW - 1) begin
          m_out    = m_bits;
          m_valid  = 1'b1;
          m_locked = 1'b1;
          m_cnt    = (m_cnt + 1) % 256;
          exp_q.push_back(m_bits);
        end
      end
      m_pos = (m_pos + 1) % FL;
    end
    #1;
  endtask

  // Serializer view: a payload bit for slots below DW. Other slots are
  // don't-care and carry either random fill or forced ones.
  function automatic logic frame_bit(input logic [DW-1:0] w, input int slot, input logic fill_one);
    if (slot < DW) return w[slot];
    if (fill_one) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic reset_a();
    bus_a.SERIAL_IN = 1'b0;
    bus_a.SYNC      = 1'b0;
    @(posedge clk);
    #2 rst_a = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    bus_a.SERIAL_IN = 1'b1;
    bus_a.SYNC      = 1'b0;
    rst_a = 1'b0;
    repeat (3) begin
      @(posedge clk);
      bus_a.SERIAL_IN = 1'($urandom_range(0, 1));
    end
    #1;
    n_cmp++; if (bus_a.PAR_OUT !== 16'h0) begin n_fail++; $display("FAIL reset_par_out: got %h expected 0000", bus_a.PAR_OUT); end
    n_cmp++; if (bus_a.PAR_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_par_valid: got %b expected 0", bus_a.PAR_VALID); end
    n_cmp++; if (bus_a.LOCKED !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", bus_a.LOCKED); end
    n_cmp++; if (bus_a.FRAME_CNT !== 8'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", bus_a.FRAME_CNT); end
    rst_a = 1'b1;
    model_reset();
  endtask

  task automatic test_frames();
    logic [DW-1:0] w;
    int v_edges[$];
    logic b;
    w = 16'hA5C3;
    reset_a();
    for (int k = 0; k < 1 + 3 * FL; k++) begin
      b = (k == 0) ? 1'($urandom_range(0, 1)) : frame_bit(w, (k - 1) % FL, 1'b0);
      drive_edge(b, 1'b0);
      if (bus_a.PAR_VALID === 1'b1) v_edges.push_back(e_cnt);
      n_cmp++; if (bus_a.PAR_VALID !== m_valid) begin n_fail++; $display("FAIL frames_valid edge %0d: got %b expected %b", e_cnt, bus_a.PAR_VALID, m_valid); end
      n_cmp++; if (bus_a.LOCKED !== (e_cnt >= 17)) begin n_fail++; $display("FAIL frames_locked edge %0d: got %b expected %b", e_cnt, bus_a.LOCKED, e_cnt >= 17); end
      if (m_valid) begin
        n_cmp++; if (bus_a.PAR_OUT !== exp_q.pop_front()) begin n_fail++; $display("FAIL frames_word edge %0d: got %h expected a5c3", e_cnt, bus_a.PAR_OUT); end
        n_cmp++; if (bus_a.FRAME_CNT !== 8'(m_cnt)) begin n_fail++; $display("FAIL frames_cnt edge %0d: got %0d expected %0d", e_cnt, bus_a.FRAME_CNT, m_cnt); end
      end
    end
    n_cmp++; if (v_edges.size() != 3) begin n_fail++; $display("FAIL frames_pulse_count: got %0d expected 3", v_edges.size()); end
    for (int i = 0; i < v_edges.size() && i < 3; i++) begin
      n_cmp++; if (v_edges[i] != 17 + 32 * i) begin n_fail++; $display("FAIL frames_pulse_edge: got %0d expected %0d", v_edges[i], 17 + 32 * i); end
    end
    n_cmp++; if (bus_a.FRAME_CNT !== 8'd3) begin n_fail++; $display("FAIL frames_final_cnt: got %0d expected 3", bus_a.FRAME_CNT); end
  endtask

  task automatic test_skip_immunity();
    int nv;
    nv = 0;
    reset_a();
    drive_edge(1'b1, 1'b0);
    for (int k = 0; k < 2 * FL; k++) begin
      drive_edge(frame_bit(16'h0001, k % FL, 1'b1), 1'b0);
      if (bus_a.PAR_VALID === 1'b1) nv++;
      n_cmp++; if (bus_a.PAR_VALID !== m_valid) begin n_fail++; $display("FAIL skip_valid edge %0d: got %b expected %b", e_cnt, bus_a.PAR_VALID, m_valid); end
      n_cmp++; if (m_locked && bus_a.PAR_OUT !== 16'h0001) begin n_fail++; $display("FAIL skip_word edge %0d: got %h expected 0001", e_cnt, bus_a.PAR_OUT); end
      if (m_valid) void'(exp_q.pop_front());
    end
    n_cmp++; if (nv != 2) begin n_fail++; $display("FAIL skip_pulse_count: got %0d expected 2", nv); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w;
    reset_a();
    drive_edge(1'($urandom_range(0, 1)), 1'b0);
    for (int f = 0; f < 256; f++) begin
      w = (f == 0) ? 16'h1234 : (f == 1) ? 16'hFFFF : 16'($urandom);
      for (int k = 0; k < FL; k++) begin
        drive_edge(frame_bit(w, k, 1'b0), 1'b0);
        n_cmp++; if (bus_a.PAR_VALID !== m_valid) begin n_fail++; $display("FAIL b2b_valid edge %0d: got %b expected %b", e_cnt, bus_a.PAR_VALID, m_valid); end
        n_cmp++; if (bus_a.PAR_OUT !== m_out) begin n_fail++; $display("FAIL b2b_hold edge %0d: got %h expected %h", e_cnt, bus_a.PAR_OUT, m_out); end
        if (m_valid) begin
          n_cmp++; if (bus_a.PAR_OUT !== exp_q.pop_front()) begin n_fail++; $display("FAIL b2b_word frame %0d: got %h expected %h", f, bus_a.PAR_OUT, w); end
          n_cmp++; if (bus_a.FRAME_CNT !== 8'(m_cnt)) begin n_fail++; $display("FAIL b2b_cnt frame %0d: got %0d expected %0d", f, bus_a.FRAME_CNT, m_cnt); end
        end
      end
    end
    n_cmp++; if (bus_a.FRAME_CNT !== 8'd0) begin n_fail++; $display("FAIL b2b_wrap: got %0d expected 0", bus_a.FRAME_CNT); end
    n_cmp++; if (bus_a.LOCKED !== 1'b1) begin n_fail++; $display("FAIL b2b_locked: got %b expected 1", bus_a.LOCKED); end
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] w;
    reset_a();
    drive_edge(1'b0, 1'b0);
    w = 16'($urandom);
    for (int k = 0; k < FL + 9; k++) begin
      drive_edge(frame_bit(w, k % FL, 1'b0), 1'b0);
      if (m_valid) void'(exp_q.pop_front());
    end
    #1 rst_a = 1'b0;
    #1;
    n_cmp++; if (bus_a.PAR_OUT !== 16'h0) begin n_fail++; $display("FAIL mid_rst_out: got %h expected 0000", bus_a.PAR_OUT); end
    n_cmp++; if (bus_a.LOCKED !== 1'b0) begin n_fail++; $display("FAIL mid_rst_locked: got %b expected 0", bus_a.LOCKED); end
    n_cmp++; if (bus_a.FRAME_CNT !== 8'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d expected 0", bus_a.FRAME_CNT); end
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b1;
    model_reset();
    w = 16'($urandom);
    drive_edge(1'b1, 1'b0);
    for (int k = 0; k < FL; k++) begin
      drive_edge(frame_bit(w, k, 1'b0), 1'b0);
      n_cmp++; if (bus_a.PAR_VALID !== (e_cnt == 17)) begin n_fail++; $display("FAIL mid_rst_valid edge %0d: got %b expected %b", e_cnt, bus_a.PAR_VALID, e_cnt == 17); end
      if (m_valid) begin
        n_cmp++; if (bus_a.PAR_OUT !== w) begin n_fail++; $display("FAIL mid_rst_word: got %h expected %h", bus_a.PAR_OUT, w); end
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_sync();
    logic [DW-1:0] w;
    logic [DW-1:0] wk;
    logic s_q[$];
    logic y_q[$];
    int nv;
    reset_a();
    drive_edge(1'b0, 1'b0);
    w = 16'($urandom);
    for (int k = 0; k < FL; k++) drive_edge(frame_bit(w, k, 1'b0), 1'b0);
    void'(exp_q.pop_front());
    // Realign mid-frame: SYNC on edge 5, payload 8001 on edges 6..21.
    wk = 16'h8001;
    nv = 0;
    for (int k = 1; k <= 30; k++) begin
      drive_edge((k >= 6 && k <= 21) ? wk[k - 6] : 1'($urandom_range(0, 1)), (k == 5));
      if (bus_a.PAR_VALID === 1'b1) nv++;
      n_cmp++; if (bus_a.PAR_VALID !== (k == 21)) begin n_fail++; $display("FAIL sync_valid k=%0d: got %b expected %b", k, bus_a.PAR_VALID, k == 21); end
      if (m_valid) void'(exp_q.pop_front());
    end
    n_cmp++; if (nv != 1) begin n_fail++; $display("FAIL sync_pulse_count: got %0d expected 1", nv); end
    n_cmp++; if (bus_a.PAR_OUT !== 16'h8001) begin n_fail++; $display("FAIL sync_word: got %h expected 8001", bus_a.PAR_OUT); end
    n_cmp++; if (bus_a.FRAME_CNT !== 8'd2) begin n_fail++; $display("FAIL sync_cnt: got %0d expected 2", bus_a.FRAME_CNT); end
    // SYNC on slot 15 kills the word. A SYNC held for 3 edges then parks
    // the cell at slot 0.
    w  = 16'($urandom);
    wk = 16'($urandom);
    s_q.push_back(1'b0); y_q.push_back(1'b1);
    for (int k = 0; k < DW; k++) begin s_q.push_back(w[k]); y_q.push_back(k == DW - 1); end
    for (int k = 0; k < 3; k++) begin s_q.push_back(1'($urandom_range(0, 1))); y_q.push_back(1'b1); end
    for (int k = 0; k < DW; k++) begin s_q.push_back(wk[k]); y_q.push_back(1'b0); end
    nv = 0;
    for (int i = 0; i < s_q.size(); i++) begin
      drive_edge(s_q[i], y_q[i]);
      if (bus_a.PAR_VALID === 1'b1) nv++;
      n_cmp++; if (bus_a.PAR_VALID !== m_valid) begin n_fail++; $display("FAIL sync2_valid i=%0d: got %b expected %b", i, bus_a.PAR_VALID, m_valid); end
      if (i == DW) begin
        n_cmp++; if (bus_a.FRAME_CNT !== 8'd2 || bus_a.PAR_OUT !== 16'h8001) begin n_fail++; $display("FAIL sync_slot15: got cnt %0d out %h expected cnt 2 out 8001", bus_a.FRAME_CNT, bus_a.PAR_OUT); end
      end
      if (m_valid) void'(exp_q.pop_front());
    end
    n_cmp++; if (nv != 1 || bus_a.PAR_OUT !== wk || bus_a.FRAME_CNT !== 8'd3) begin n_fail++; $display("FAIL sync_held: got pulses %0d out %h cnt %0d expected 1 %h 3", nv, bus_a.PAR_OUT, bus_a.FRAME_CNT, wk); end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp;
    reset_a();
    for (int k = 0; k < 1200; k++) begin
      drive_edge(1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0));
      n_cmp++; if (bus_a.PAR_VALID !== m_valid) begin n_fail++; $display("FAIL rand_valid edge %0d: got %b expected %b", e_cnt, bus_a.PAR_VALID, m_valid); end
      n_cmp++; if (bus_a.LOCKED !== m_locked) begin n_fail++; $display("FAIL rand_locked edge %0d: got %b expected %b", e_cnt, bus_a.LOCKED, m_locked); end
      n_cmp++; if (bus_a.FRAME_CNT !== 8'(m_cnt)) begin n_fail++; $display("FAIL rand_cnt edge %0d: got %0d expected %0d", e_cnt, bus_a.FRAME_CNT, m_cnt); end
      if (m_valid) begin
        exp = exp_q.pop_front();
        n_cmp++; if (bus_a.PAR_OUT !== exp) begin n_fail++; $display("FAIL rand_word edge %0d: got %h expected %h", e_cnt, bus_a.PAR_OUT, exp); end
      end else begin
        n_cmp++; if (bus_a.PAR_OUT !== m_out) begin n_fail++; $display("FAIL rand_hold edge %0d: got %h expected %h", e_cnt, bus_a.PAR_OUT, m_out); end
      end
    end
  endtask

  task automatic test_pipe0();
    logic [DW-1:0] w;
    w = 16'hC3A5;
    @(posedge clk);
    #1 rst_b = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      bus_b.SERIAL_IN = (k <= DW) ? w[k - 1] : 1'b0;
      @(posedge clk);
      #1;
      n_cmp++; if (bus_b.PAR_VALID !== (k == DW)) begin n_fail++; $display("FAIL pipe0_valid edge %0d: got %b expected %b", k, bus_b.PAR_VALID, k == DW); end
      if (k == DW) begin
        n_cmp++; if (bus_b.PAR_OUT !== 16'hC3A5) begin n_fail++; $display("FAIL pipe0_word: got %h expected c3a5", bus_b.PAR_OUT); end
        n_cmp++; if (bus_b.FRAME_CNT !== 8'd1 || bus_b.LOCKED !== 1'b1) begin n_fail++; $display("FAIL pipe0_status: got cnt %0d lock %b expected 1 1", bus_b.FRAME_CNT, bus_b.LOCKED); end
      end
    end
  endtask

  initial begin
    bus_a.SERIAL_IN = 1'b0;
    bus_a.SYNC      = 1'b0;
    bus_b.SERIAL_IN = 1'b0;
    bus_b.SYNC      = 1'b0;
    model_reset();
    test_reset();
    test_frames();
    test_skip_immunity();
    test_back_to_back();
    test_reset_mid_frame();
    test_sync();
    test_random();
    test_pipe0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
